// File: rtl/semafor_monitor.sv
// Passive monitor for the two semafor light outputs: decodes each light into a
// phase code, measures phase lengths and raises sticky legality/timing errors.

module semafor_light_track #(
    parameter int CNT_W     = 16,
    parameter int MAX_PHASE = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rgb,
    output logic [2:0]       cur,
    output logic [2:0]       phase,
    output logic             phase_done,
    output logic [CNT_W-1:0] phase_len,
    output logic             pat_hit,
    output logic             seq_hit,
    output logic             tmo_hit
);
    localparam logic [2:0] PH_OFF = 3'd0;
    localparam logic [2:0] PH_R   = 3'd1;
    localparam logic [2:0] PH_RY  = 3'd2;
    localparam logic [2:0] PH_G   = 3'd3;
    localparam logic [2:0] PH_Y   = 3'd4;
    localparam logic [2:0] PH_ILL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MAX_PHASE);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             first;
    logic             changed;
    logic             legal;

    always_comb begin
        case (rgb)
            3'b000:  cur = PH_OFF;
            3'b100:  cur = PH_R;
            3'b110:  cur = PH_RY;
            3'b001:  cur = PH_G;
            3'b010:  cur = PH_Y;
            default: cur = PH_ILL;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        if (cur == PH_R)
            legal = 1'b1;
        else
            case (phase)
                PH_R:    legal = (cur == PH_RY) || (cur == PH_OFF);
                PH_RY:   legal = (cur == PH_G);
                PH_G:    legal = (cur == PH_Y);
                PH_Y:    legal = (cur == PH_OFF);
                PH_OFF:  legal = (cur == PH_Y);
                default: legal = 1'b0;
            endcase
    end

    assign changed = !first && (cur != phase);

    always_comb begin
        if (first || changed)
            cnt_nxt = CNT_ONE;
        else if (cnt == CNT_MAX)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + CNT_ONE;
    end

    // ILLEGAL on either side of a change is a pattern problem, not a sequence one
    assign pat_hit = (cur == PH_ILL) || (changed && phase == PH_ILL);
    assign seq_hit = changed && (cur != PH_ILL) && (phase != PH_ILL) && !legal;
    assign tmo_hit = (cnt_nxt == CNT_TMO) && (cur != PH_OFF) && (cur != PH_ILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_OFF;
            phase_done <= 1'b0;
            phase_len  <= '0;
            cnt        <= '0;
            first      <= 1'b1;
        end else begin
            phase      <= cur;
            phase_done <= changed;
            cnt        <= cnt_nxt;
            first      <= 1'b0;
            if (changed)
                phase_len <= cnt;
        end
    end
endmodule

module semafor_monitor #(
    parameter int CNT_W     = 16,
    parameter int MAX_PHASE = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_err,
    input  logic [2:0]       RGB_A,
    input  logic [2:0]       RGB_B,
    output logic [2:0]       phase_A,
    output logic [2:0]       phase_B,
    output logic             phase_done_A,
    output logic [CNT_W-1:0] phase_len_A,
    output logic             phase_done_B,
    output logic [CNT_W-1:0] phase_len_B,
    output logic             err_pattern,
    output logic             err_sequence,
    output logic             err_conflict,
    output logic             err_timeout,
    output logic             err_any
);
    localparam int NUM_LIGHTS = 2;

    logic [NUM_LIGHTS-1:0][2:0]       rgb_w, cur_w, ph_w;
    logic [NUM_LIGHTS-1:0]            done_w, pat_w, seq_w, tmo_w, go_w;
    logic [NUM_LIGHTS-1:0][CNT_W-1:0] len_w;
    logic [3:0]                       err_q, err_hit, err_nxt;

    assign rgb_w = {RGB_B, RGB_A};

    for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_light
        semafor_light_track #(
            .CNT_W     (CNT_W),
            .MAX_PHASE (MAX_PHASE)
        ) u_trk (
            .clk        (clk),
            .reset      (reset),
            .rgb        (rgb_w[i]),
            .cur        (cur_w[i]),
            .phase      (ph_w[i]),
            .phase_done (done_w[i]),
            .phase_len  (len_w[i]),
            .pat_hit    (pat_w[i]),
            .seq_hit    (seq_w[i]),
            .tmo_hit    (tmo_w[i])
        );
        // RY is a prepare-to-go aspect, so only G and Y count as go
        assign go_w[i] = (cur_w[i] == 3'd3) || (cur_w[i] == 3'd4);
    end

    assign err_hit = {|tmo_w, &go_w, |seq_w, |pat_w};
    assign err_nxt = (clr_err ? 4'b0 : err_q) | err_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q   <= '0;
            err_any <= 1'b0;
        end else begin
            err_q   <= err_nxt;
            err_any <= |err_nxt;
        end
    end

    assign phase_A      = ph_w[0];
    assign phase_B      = ph_w[1];
    assign phase_done_A = done_w[0];
    assign phase_done_B = done_w[1];
    assign phase_len_A  = len_w[0];
    assign phase_len_B  = len_w[1];
    assign err_pattern  = err_q[0];
    assign err_sequence = err_q[1];
    assign err_conflict = err_q[2];
    assign err_timeout  = err_q[3];
endmodule

// File: tb/tb_semafor_monitor.sv
// Bench for semafor_monitor: directed scenarios plus random traffic checked
// against a phase-level reference model of both lights.

module tb_semafor_monitor;
    logic        clk = 1'b0;
    logic        reset, clr_err;
    logic [2:0]  rgb_a, rgb_b;

    logic [2:0]  ph_a, ph_b;
    logic        done_a, done_b;
    logic [15:0] len_a, len_b;
    logic        e_pat, e_seq, e_con, e_tmo, e_any;

    logic [2:0]  t_ph_a, t_ph_b;
    logic        t_done_a, t_done_b;
    logic [15:0] t_len_a, t_len_b;
    logic        t_pat, t_seq, t_con, t_tmo, t_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    semafor_monitor dut (
        .clk(clk), .reset(reset), .clr_err(clr_err), .RGB_A(rgb_a), .RGB_B(rgb_b),
        .phase_A(ph_a), .phase_B(ph_b), .phase_done_A(done_a), .phase_len_A(len_a),
        .phase_done_B(done_b), .phase_len_B(len_b), .err_pattern(e_pat),
        .err_sequence(e_seq), .err_conflict(e_con), .err_timeout(e_tmo), .err_any(e_any)
    );

    semafor_monitor #(.CNT_W(16), .MAX_PHASE(10)) dut_t (
        .clk(clk), .reset(reset), .clr_err(clr_err), .RGB_A(rgb_a), .RGB_B(rgb_b),
        .phase_A(t_ph_a), .phase_B(t_ph_b), .phase_done_A(t_done_a), .phase_len_A(t_len_a),
        .phase_done_B(t_done_b), .phase_len_B(t_len_b), .err_pattern(t_pat),
        .err_sequence(t_seq), .err_conflict(t_con), .err_timeout(t_tmo), .err_any(t_any)
    );

    // reference model: phase per light, run length, and sticky flags
    bit legal [8][8];
    int m_ph [2], m_cnt [2], m_len [2];
    bit m_first [2], m_done [2];
    bit m_pat, m_seq, m_con, m_to, m_to10;

    function automatic int dec(input logic [2:0] p);
        case (p)
            3'b000:  return 0;
            3'b100:  return 1;
            3'b110:  return 2;
            3'b001:  return 3;
            3'b010:  return 4;
            default: return 7;
        endcase
    endfunction

    task automatic tick();
        int cur [2];
        bit pat, seq, to, to10;
        cur[0] = dec(rgb_a);
        cur[1] = dec(rgb_b);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_first[i] = 1; m_done[i] = 0;
            end
            m_pat = 0; m_seq = 0; m_con = 0; m_to = 0; m_to10 = 0;
        end else begin
            pat = 0; seq = 0; to = 0; to10 = 0;
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                if (cur[i] == 7) pat = 1;
                if (m_first[i]) m_cnt[i] = 1;
                else if (cur[i] != m_ph[i]) begin
                    if (m_ph[i] == 7 || cur[i] == 7) pat = 1;
                    else if (!legal[m_ph[i]][cur[i]]) seq = 1;
                    m_done[i] = 1;
                    m_len[i] = m_cnt[i];
                    m_cnt[i] = 1;
                end else if (m_cnt[i] < 65535) m_cnt[i]++;
                m_first[i] = 0;
                m_ph[i] = cur[i];
                if (cur[i] != 0 && cur[i] != 7) begin
                    if (m_cnt[i] == 1000) to = 1;
                    if (m_cnt[i] == 10) to10 = 1;
                end
            end
            m_pat  = (m_pat && !clr_err) || pat;
            m_seq  = (m_seq && !clr_err) || seq;
            m_con  = (m_con && !clr_err) || ((cur[0] == 3 || cur[0] == 4) && (cur[1] == 3 || cur[1] == 4));
            m_to   = (m_to && !clr_err) || to;
            m_to10 = (m_to10 && !clr_err) || to10;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] a, input logic [2:0] b, input int n);
        rgb_a = a;
        rgb_b = b;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1; clr_err = 0; rgb_a = 3'b000; rgb_b = 3'b000;
        repeat (5) tick();
        checks++;
        if ({ph_a, ph_b, done_a, done_b, len_a, len_b, e_pat, e_seq, e_con, e_tmo, e_any} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ph=%0d/%0d done=%b%b len=%0d/%0d err=%b%b%b%b%b, want all 0",
                     ph_a, ph_b, done_a, done_b, len_a, len_b, e_pat, e_seq, e_con, e_tmo, e_any);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        run(3'b100, 3'b001, 50);
        checks++;
        if (ph_a !== 3'd1 || ph_b !== 3'd3 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got ph_a=%0d ph_b=%0d done_a=%b, want 1 3 0", ph_a, ph_b, done_a);
        end
        run(3'b110, 3'b001, 1);
        checks++;
        if (ph_a !== 3'd2 || done_a !== 1'b1 || len_a !== 16'd50 || e_any !== 1'b0) begin
            errors++;
            $display("FAIL basic_change: got ph_a=%0d done_a=%b len_a=%0d err_any=%b, want 2 1 50 0",
                     ph_a, done_a, len_a, e_any);
        end
        run(3'b110, 3'b001, 1);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: got done_a=%b, want 0", done_a);
        end
    endtask

    task automatic test_full_cycle();
        logic [2:0] sa [5] = '{3'b100, 3'b110, 3'b001, 3'b010, 3'b100};
        logic [2:0] sb [5] = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b001};
        int         sn [5] = '{20, 3, 30, 5, 1};
        int         want [4] = '{20, 3, 30, 5};
        int         lens [$];
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < sn[s]; k++) begin
                run(sa[s], sb[s], 1);
                if (done_a && !(s == 0 && k == 0)) lens.push_back(int'(len_a));
            end
        checks++;
        if (lens.size() != 4) begin
            errors++;
            $display("FAIL cycle_count: got %0d A phases, want 4", lens.size());
        end else
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lens[i] != want[i]) begin
                    errors++;
                    $display("FAIL cycle_len%0d: got %0d, want %0d", i, lens[i], want[i]);
                end
            end
        checks++;
        if ({e_pat, e_seq, e_con, e_tmo, e_any} !== 5'b0) begin
            errors++;
            $display("FAIL cycle_errs: got %b, want 00000", {e_pat, e_seq, e_con, e_tmo, e_any});
        end
    endtask

    task automatic test_forced_red();
        run(3'b110, 3'b100, 1);
        run(3'b001, 3'b100, 3);
        run(3'b100, 3'b100, 1);
        checks++;
        if (e_seq !== 1'b0 || e_any !== 1'b0) begin
            errors++;
            $display("FAIL forced_red: got err_sequence=%b err_any=%b, want 0 0", e_seq, e_any);
        end
        run(3'b001, 3'b100, 1);
        checks++;
        if (e_seq !== 1'b1 || e_any !== 1'b1) begin
            errors++;
            $display("FAIL bad_seq: got err_sequence=%b err_any=%b, want 1 1", e_seq, e_any);
        end
        clr_err = 1;
        run(3'b001, 3'b100, 1);
        clr_err = 0;
        checks++;
        if (e_seq !== 1'b0 || e_any !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got err_sequence=%b err_any=%b, want 0 0", e_seq, e_any);
        end
    endtask

    task automatic test_pattern_conflict();
        run(3'b101, 3'b100, 1);
        checks++;
        if (ph_a !== 3'd7 || e_pat !== 1'b1 || e_any !== 1'b1) begin
            errors++;
            $display("FAIL pattern: got ph_a=%0d err_pattern=%b err_any=%b, want 7 1 1", ph_a, e_pat, e_any);
        end
        run(3'b001, 3'b010, 1);
        checks++;
        if (e_con !== 1'b1) begin
            errors++;
            $display("FAIL conflict: got err_conflict=%b, want 1", e_con);
        end
    endtask

    task automatic test_timeout();
        reset = 1;
        tick();
        reset = 0;
        run(3'b100, 3'b100, 9);
        checks++;
        if (t_tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b after 9 R cycles, want 0", t_tmo);
        end
        run(3'b100, 3'b100, 1);
        checks++;
        if (t_tmo !== 1'b1 || t_any !== 1'b1 || e_tmo !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got t_tmo=%b t_any=%b main_tmo=%b, want 1 1 0", t_tmo, t_any, e_tmo);
        end
        clr_err = 1;
        run(3'b000, 3'b000, 1);
        clr_err = 0;
        run(3'b000, 3'b000, 49);
        checks++;
        if (t_tmo !== 1'b0 || t_any !== 1'b0) begin
            errors++;
            $display("FAIL off_untimed: got t_tmo=%b t_any=%b, want 0 0", t_tmo, t_any);
        end
    endtask

    task automatic test_reset_mid();
        run(3'b100, 3'b100, 1);
        run(3'b110, 3'b100, 1);
        run(3'b001, 3'b100, 15);
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (done_a !== 1'b0 || len_a !== 16'd0 || ph_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got done_a=%b len_a=%0d ph_a=%0d, want 0 0 0", done_a, len_a, ph_a);
        end
        run(3'b010, 3'b100, 1);
        checks++;
        if (done_a !== 1'b0 || e_seq !== 1'b0 || ph_a !== 3'd4) begin
            errors++;
            $display("FAIL first_sample: got done_a=%b err_sequence=%b ph_a=%0d, want 0 0 4", done_a, e_seq, ph_a);
        end
        run(3'b010, 3'b100, 3);
        run(3'b100, 3'b100, 1);
        checks++;
        if (done_a !== 1'b1 || len_a !== 16'd4) begin
            errors++;
            $display("FAIL restart_len: got done_a=%b len_a=%0d, want 1 4", done_a, len_a);
        end
    endtask

    task automatic test_random();
        logic [2:0] pats [5] = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b010};
        logic [46:0] got, exp;
        reset = 1;
        tick();
        reset = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(9) < 3) rgb_a = pats[$urandom_range(4)];
            if ($urandom_range(9) < 3) rgb_b = pats[$urandom_range(4)];
            if ($urandom_range(29) == 0) rgb_a = 3'($urandom);
            clr_err = ($urandom_range(19) == 0);
            reset   = ($urandom_range(99) == 0);
            if ($urandom_range(49) == 0) begin
                rgb_a = 3'b100;
                repeat (12) tick();
            end
            tick();
            got = {ph_a, ph_b, done_a, done_b, len_a, len_b, e_pat, e_seq, e_con, e_tmo, e_any, t_tmo};
            exp = {3'(m_ph[0]), 3'(m_ph[1]), m_done[0], m_done[1], 16'(m_len[0]), 16'(m_len[1]),
                   m_pat, m_seq, m_con, m_to, m_pat | m_seq | m_con | m_to, m_to10};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h, want %h", n, got, exp);
            end
        end
        reset = 0;
        clr_err = 0;
    endtask

    initial begin
        for (int p = 0; p < 8; p++) begin
            legal[p][p] = 1;
            legal[p][1] = 1;
        end
        legal[1][2] = 1; legal[2][3] = 1; legal[3][4] = 1; legal[4][1] = 1;
        legal[4][0] = 1; legal[0][4] = 1; legal[1][0] = 1;

        test_reset();
        test_basic();
        test_full_cycle();
        test_forced_red();
        test_pattern_conflict();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/semafor_monitor.md
Name: semafor_monitor

Overview:
- Passive checker/decoder on the consumer side of the semafor light outputs.
- Samples RGB_A/RGB_B every clock and decodes each into a phase code.
- Checks pattern legality, phase ordering, A/B conflicts and phase duration; raises sticky error flags.
- Reports the length of every completed phase. Sits next to semafor in system and bench builds; drives nothing back into the controller.

Parameters:
CNT_W, 16, width of the phase-length counters and of phase_len_* outputs
MAX_PHASE, 1000, cycles a non-OFF phase may persist before err_timeout (must be < 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clr_err  input  1  synchronous clear of sticky error flags
RGB_A  input  3  light A: bit2 red, bit1 yellow, bit0 green
RGB_B  input  3  light B, same encoding
phase_A  output  3  decoded phase of A: 0 OFF, 1 R, 2 RY, 3 G, 4 Y, 7 ILLEGAL
phase_B  output  3  decoded phase of B, same coding
phase_done_A  output  1  one-cycle pulse: an A phase just ended
phase_len_A  output  CNT_W  length in cycles of the ended A phase, valid with phase_done_A
phase_done_B  output  1  as for A
phase_len_B  output  CNT_W  as for A
err_pattern  output  1  sticky: an ILLEGAL pattern was seen
err_sequence  output  1  sticky: an illegal phase transition was seen
err_conflict  output  1  sticky: both lights in G or Y in the same cycle
err_timeout  output  1  sticky: a non-OFF phase reached MAX_PHASE cycles
err_any  output  1  OR of the four sticky flags (registered)

Behaviour:
- Decode: 000 OFF, 100 R, 110 RY, 001 G, 010 Y; every other pattern is ILLEGAL.
- All outputs are registered. At rising edge k the block decodes the inputs, compares them with the phase registered at edge k-1 and updates all outputs. An input change is therefore visible one cycle later.
- Reset: phase_A/B=0, phase_done_*=0, phase_len_*=0, all err_*=0, counters=0, first_A/B=1.
- Legal transitions per light:
  - same phase→same phase
  - R→RY, RY→G, G→Y, Y→R
  - Y↔OFF (blink)
  - any→R (forced red)
  - anything→OFF only from Y or R
  - Any other change sets err_sequence.
- A transition into or out of ILLEGAL sets err_pattern only; it does not also set err_sequence.
- first_X=1: the first sample after reset is not sequence-checked. first_X clears at that edge.
- Phase counter per light:
  - Holds cycles spent in the current phase. It is 1 on the first cycle of a phase.
  - On a phase change, the counter value is copied to phase_len_X, phase_done_X pulses for 1 cycle and the counter reloads to 1.
  - There is no phase_done at the first sample after reset.
  - The counter saturates at 2^CNT_W-1.
- Timeout:
  - When the counter equals MAX_PHASE and the phase is neither OFF nor ILLEGAL, err_timeout is set.
  - OFF is never timed. The blink cadence belongs to the controller.
- Conflict: phase_A∈{G,Y} and phase_B∈{G,Y} (decoded at the same edge) sets err_conflict. RY counts as not-go.
- Sticky flags:
  - Held until reset or clr_err.
  - If clr_err and a new error occur at the same edge, the new error wins (flag stays 1).
  - clr_err does not touch counters or phases.
- Reset mid-phase: everything returns to reset values, the partial phase is discarded and no phase_done is issued.
- err_any is the registered OR of the err_* next-state values. It asserts in the same cycle as the individual flag.

Test Plan:
- Reset 5 cycles. Drive A=100/B=001 for 50 cycles, then A=110 → phase_A=1 during the R phase, then 2 one cycle after the change. phase_done_A pulses with phase_len_A=50. No errors.
- A full cycle R(20)→RY(3)→G(30)→Y(5)→R with B the mirror (G when A is R, etc.) → phase_len_A sequence 20, 3, 30, 5. All err_* stay 0.
- A: G→R directly is legal (forced red) → no error. Then A: R→G → err_sequence=1 and err_any=1 from the next cycle. Pulse clr_err → both return to 0.
- Drive A=101 → phase_A=7 and err_pattern=1. Drive A=001 and B=010 together → err_conflict=1.
- MAX_PHASE=10 override, hold A=100 → err_timeout rises after the 10th R cycle. Hold A=000 for 50 cycles → no timeout.
- Reset asserted for 1 cycle mid G phase (counter ~15), then A=010 → no phase_done at reset. The first sample after reset raises no err_sequence, and phase_len_A restarts from 1.
